// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: clears x1..x31 after reset, then round-robin arbitrates two writeback requesters onto the register-file write port.
module regfile_wb_arbiter #(
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [4:0]  req0_addr,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [4:0]  req1_addr,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  output logic        we,
  output logic [4:0]  wa,
  output logic [31:0] wd,
  output logic        init_done
);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t      state;
  logic [4:0]  cnt;
  logic        ptr;
  logic        run;
  logic        grant0;
  logic        grant1;
  // rst gates the readies so they drop the instant reset asserts
  assign run        = rst && state == RUN;
  assign grant0     = run && req0_valid && (!req1_valid || !ptr);
  assign grant1     = run && req1_valid && (!req0_valid || ptr);
  assign req0_ready = grant0;
  assign req1_ready = grant1;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if (CLEAR_ON_RESET) state <= CLEAR;
      else state <= RUN;
      cnt       <= 5'd1;
      ptr       <= 1'b0;
      we        <= 1'b0;
      wa        <= 5'd0;
      wd        <= 32'd0;
      init_done <= 1'b0;
    end else if (state == CLEAR) begin
      we  <= 1'b1;
      wa  <= cnt;
      wd  <= 32'd0;
      cnt <= cnt + 5'd1;
      if (cnt == 5'd31) begin
        state     <= RUN;
        init_done <= 1'b1;
      end
    end else begin
      init_done <= 1'b1;
      we        <= (grant0 && req0_addr != 5'd0) || (grant1 && req1_addr != 5'd0);
      if (grant0 || grant1) begin
        wa  <= grant0 ? req0_addr : req1_addr;
        wd  <= grant0 ? req0_data : req1_data;
        ptr <= grant0;
      end
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed checks of clear sequence, arbitration, x0 drop and reset abort.
module tb_regfile_wb_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0_valid = 1'b0;
  logic [4:0]  req0_addr = 5'd0;
  logic [31:0] req0_data = 32'd0;
  logic        req1_valid = 1'b0;
  logic [4:0]  req1_addr = 5'd0;
  logic [31:0] req1_data = 32'd0;
  logic        c_req0_ready, c_req1_ready, c_we, c_init_done;
  logic [4:0]  c_wa;
  logic [31:0] c_wd;
  logic        n_req0_ready, n_req1_ready, n_we, n_init_done;
  logic [4:0]  n_wa;
  logic [31:0] n_wd;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.CLEAR_ON_RESET(1'b1)) u_clr (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(c_req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(c_req1_ready),
    .we(c_we), .wa(c_wa), .wd(c_wd), .init_done(c_init_done)
  );

  regfile_wb_arbiter #(.CLEAR_ON_RESET(1'b0)) u_noclr (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(n_req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(n_req1_ready),
    .we(n_we), .wa(n_wa), .wd(n_wd), .init_done(n_init_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick();
    tick();
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    check("rst_we", c_we, 0);
    check("rst_wa", c_wa, 0);
    check("rst_wd", c_wd, 0);
    check("rst_init", c_init_done, 0);
    check("rst_rdy0_noclr", n_req0_ready, 0);
    check("rst_rdy1_noclr", n_req1_ready, 0);
    req0_addr = 5'd7;
    req0_data = 32'h0000_0055;
    req1_addr = 5'd9;
    req1_data = 32'h0000_0099;
    #2;
    rst = 1'b1;
    #1;
    check("noclr_rdy0_first", n_req0_ready, 1);
    check("clr_rdy0_in_clear", c_req0_ready, 0);
    for (int i = 1; i <= 31; i++) begin
      tick();
      check("clr_we", c_we, 1);
      check("clr_wa", c_wa, i);
      check("clr_wd", c_wd, 0);
      check("clr_init", c_init_done, i == 31);
      if (i < 31) begin
        check("clr_rdy0", c_req0_ready, 0);
        check("clr_rdy1", c_req1_ready, 0);
      end
      if (i == 1) begin
        check("noclr_init", n_init_done, 1);
        check("noclr_we", n_we, 1);
        check("noclr_wa", n_wa, 7);
        check("noclr_wd", n_wd, 32'h55);
      end
      if (i == 31) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
    end
    tick();
    check("idle_we", c_we, 0);
    check("idle_wa_hold", c_wa, 31);
    check("idle_wd_hold", c_wd, 0);

    req0_valid = 1'b1;
    req0_addr = 5'd5;
    req0_data = 32'h0000_000A;
    #1;
    check("r0_ready", c_req0_ready, 1);
    check("r0_r1_ready", c_req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    check("r0_we", c_we, 1);
    check("r0_wa", c_wa, 5);
    check("r0_wd", c_wd, 32'h0000_000A);

    req1_valid = 1'b1;
    req1_addr = 5'd0;
    req1_data = 32'hFFFF_FFFF;
    #1;
    check("x0_ready", c_req1_ready, 1);
    tick();
    req1_valid = 1'b0;
    check("x0_we", c_we, 0);
    check("x0_wa", c_wa, 0);
    check("x0_wd", c_wd, 32'hFFFF_FFFF);

    req0_valid = 1'b1;
    req0_addr = 5'd3;
    req0_data = 32'h0000_0033;
    req1_valid = 1'b1;
    req1_addr = 5'd4;
    req1_data = 32'h0000_0044;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("rr_rdy0", c_req0_ready, k % 2 == 0);
      check("rr_rdy1", c_req1_ready, k % 2 == 1);
      tick();
      check("rr_we", c_we, 1);
      check("rr_wa", c_wa, (k % 2 == 0) ? 3 : 4);
      check("rr_wd", c_wd, (k % 2 == 0) ? 32'h33 : 32'h44);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    check("hold_we", c_we, 0);
    check("hold_wa", c_wa, 4);
    check("hold_wd", c_wd, 32'h44);

    rst = 1'b0;
    #1;
    rst = 1'b1;
    for (int i = 1; i <= 9; i++) tick();
    check("mid_wa9", c_wa, 9);
    rst = 1'b0;
    #1;
    check("abort_we", c_we, 0);
    check("abort_wa", c_wa, 0);
    check("abort_init", c_init_done, 0);
    #2;
    rst = 1'b1;
    tick();
    check("restart_we", c_we, 1);
    check("restart_wa", c_wa, 1);
    for (int i = 2; i <= 31; i++) tick();
    check("restart_wa31", c_wa, 31);
    check("restart_init", c_init_done, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
